// File: rtl/universal_shift_reg_if.sv
// Request/response bundle for universal_shift_reg: control FSM (master) drives
// requests, the shift register (slave) returns contents and busy/done status.
interface universal_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
);
    logic             start;
    logic [2:0]       op;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] din;
    logic             sin_lsb;
    logic             sin_msb;
    logic [WIDTH-1:0] dout;
    logic             so_msb;
    logic             so_lsb;
    logic             busy;
    logic             done;

    modport master (
        output start, op, amt, din, sin_lsb, sin_msb,
        input  dout, so_msb, so_lsb, busy, done
    );

    modport slave (
        input  start, op, amt, din, sin_lsb, sin_msb,
        output dout, so_msb, so_lsb, busy, done
    );
endinterface

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold/load/clear plus multi-step shifts and rotates
// launched by a single start pulse, with busy/done progress reporting.
//
// state  | meaning
// IDLE   | waiting for start; single-edge ops complete here
// RUN    | applying latched op once per edge until remaining count expires
module universal_shift_reg #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    universal_shift_reg_if.slave  bus
);
    localparam logic [2:0] OP_HOLD  = 3'b000;
    localparam logic [2:0] OP_SHL   = 3'b001;
    localparam logic [2:0] OP_SHR   = 3'b010;
    localparam logic [2:0] OP_LOAD  = 3'b011;
    localparam logic [2:0] OP_ROL   = 3'b100;
    localparam logic [2:0] OP_ROR   = 3'b101;
    localparam logic [2:0] OP_ASR   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state;
    logic [2:0]       r_op;
    logic [AMT_W-1:0] r_rem;
    logic [WIDTH-1:0] r_dout;
    logic             r_busy;
    logic             r_done;

    function automatic logic [WIDTH-1:0] step_fn(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] d,
        input logic             sl,
        input logic             sm
    );
        logic [WIDTH-1:0] res;
        res = d;
        case (op)
            OP_SHL:  res = {d[WIDTH-2:0], sl};
            OP_SHR:  res = {sm, d[WIDTH-1:1]};
            OP_ROL:  res = {d[WIDTH-2:0], d[WIDTH-1]};
            OP_ROR:  res = {d[0], d[WIDTH-1:1]};
            OP_ASR:  res = {d[WIDTH-1], d[WIDTH-1:1]};
            default: res = d;
        endcase
        return res;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_op    <= OP_HOLD;
            r_rem   <= '0;
            r_dout  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    if (bus.start) begin
                        r_op <= bus.op;
                        case (bus.op)
                            OP_HOLD:  r_done <= 1'b1;
                            OP_LOAD: begin
                                r_dout <= bus.din;
                                r_done <= 1'b1;
                            end
                            OP_CLEAR: begin
                                r_dout <= '0;
                                r_done <= 1'b1;
                            end
                            default: begin
                                if (bus.amt == '0) begin
                                    r_done <= 1'b1;
                                end else begin
                                    r_dout <= step_fn(bus.op, r_dout, bus.sin_lsb, bus.sin_msb);
                                    if (bus.amt == AMT_W'(1)) begin
                                        r_done <= 1'b1;
                                    end else begin
                                        r_rem   <= bus.amt - AMT_W'(1);
                                        r_busy  <= 1'b1;
                                        r_state <= S_RUN;
                                    end
                                end
                            end
                        endcase
                    end
                end
                S_RUN: begin
                    r_dout <= step_fn(r_op, r_dout, bus.sin_lsb, bus.sin_msb);
                    if (r_rem == AMT_W'(1)) begin
                        r_rem   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_rem <= r_rem - AMT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.dout   = r_dout;
    assign bus.so_msb = r_dout[WIDTH-1];
    assign bus.so_lsb = r_dout[0];
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
- Parametrised universal shift register for general datapath use.
- Supports hold, parallel load, clear, logical shift left and right with serial inputs, rotate left and right, and arithmetic shift right.
- Runs a multi-step operation from a single start pulse.
- Reports progress with a busy/done handshake so control FSMs can issue shift-by-N requests without cycle counting.

Parameters:
- WIDTH, 8: register width in bits; must be ≥2.
- AMT_W, 4: width of the step-count input; max steps per request = 2^AMT_W-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request strobe; sampled only in IDLE.
- op  input  3  operation, latched on accepted start:
  - 000 hold
  - 001 shl
  - 010 shr
  - 011 load
  - 100 rol
  - 101 ror
  - 110 asr
  - 111 clear
- amt  input  AMT_W  number of steps for shift-class ops (001, 010, 100, 101, 110); latched on accepted start.
- din  input  WIDTH  parallel load data; sampled on the start edge.
- sin_lsb  input  1  serial bit inserted at bit 0 on each shl step; sampled every step.
- sin_msb  input  1  serial bit inserted at bit WIDTH-1 on each shr step; sampled every step.
- dout  output  WIDTH  register contents.
- so_msb  output  1  equals dout[WIDTH-1] (combinational from register).
- so_lsb  output  1  equals dout[0].
- busy  output  1  high while further steps of an accepted request remain.
- done  output  1  one-cycle pulse after the final update of a request.

Behaviour:
- Reset (rst=1 at an edge): dout=0, busy=0, done=0, state=IDLE, remaining count=0. This has priority over everything, including mid-RUN.
- Step definitions (one step = one edge):
  - shl: {dout[WIDTH-2:0], sin_lsb}
  - shr: {sin_msb, dout[WIDTH-1:1]}
  - rol: {dout[WIDTH-2:0], dout[WIDTH-1]}
  - ror: {dout[0], dout[WIDTH-1:1]}
  - asr: {dout[WIDTH-1], dout[WIDTH-1:1]}
- done defaults to 0 every cycle unless set as below.
- States: IDLE, RUN.
- IDLE, start=1 sampled at edge k:
  - load: dout=din. hold: unchanged. clear: dout=0. In each case done=1 after edge k, stay IDLE, busy stays 0; amt is ignored.
  - Shift-class with amt=0: dout unchanged, done=1 after edge k, stay IDLE.
  - Shift-class with amt=1: one step at edge k, done=1 after edge k, stay IDLE.
  - Shift-class with amt≥2: step 1 at edge k, remaining=amt-1, busy=1, go to RUN.
- IDLE, start=0: hold dout, busy=0.
- RUN, each edge: apply the latched op for one step and decrement remaining. On the edge where remaining was 1: go to IDLE, busy=0, done=1.
- Latency:
  - A request of amt=N steps updates dout on edges k..k+N-1.
  - busy is high in the N-1 cycles following edges k..k+N-2.
  - done is high in the single cycle following edge k+N-1.
- start during RUN is ignored; op, amt and din changes during RUN are ignored (latched copies are used). A new start is accepted in the cycle done is high, because state is already IDLE.
- amt > WIDTH is legal: steps continue, e.g. logical shifts fully flush to the serial fill.
- Serial inputs are sampled fresh on every step, not latched.
- No illegal op encodings exist; all eight values are defined.

Test Plan:
1. WIDTH=8. Reset, then start with op=011, din=0xA5 → dout=0xA5 after the edge, done=1 for one cycle, busy=0 throughout.
2. From 0xA5, start with op=100 (rol), amt=3 → dout sequence 0x4B, 0x96, 0x2D on consecutive edges; busy high 2 cycles; done pulses in the cycle after 0x2D appears; so_msb=0, so_lsb=1 at end.
3. From 0x96, start with op=110 (asr), amt=2 → 0xCB then 0xE5; done one cycle after 0xE5. Then start with op=001, amt=0 → dout stays 0xE5, done next cycle, busy never asserted.
4. From 0x00, start with op=001 (shl), sin_lsb=1, amt=8 → dout fills 0x01, 0x03, …, 0xFF; busy 7 cycles; done once.
5. From 0xFF, start with op=010 (shr), sin_msb=0, amt=9 → dout reaches 0x00 after 8 steps and stays 0x00 on step 9; busy 8 cycles. A second start with op=111 asserted mid-RUN is ignored and leaves no extra done.
6. Start with op=100, amt=10 from 0x5A; assert rst at the 4th edge → next cycle dout=0x00, busy=0, done=0; no done pulse ever follows for that request.
